// File: rtl/ram_burst_cache_reader_if.sv
// ram_burst_cache_reader_if
//   Bundles the user read port and the DDR3 UI read side of the burst cache reader.
//   User side : rd_req, rd_addr, flush -> block; rd_ready, rd_valid, rd_data, miss_count <- block
//   RAM side  : ram_address, ram_cmd, ram_en -> UI; ram_rdy, ram_rd_valid,
//               ram_rd_data_end, ram_rd_data <- UI
//   modport slave  : view taken by the cache reader itself
//   modport master : view taken by whatever drives requests and models the UI
interface ram_burst_cache_reader_if #(
    parameter int ADDR_W = 27,
    parameter int WORD_W = 16,
    parameter int BEAT_W = 64
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              flush;
    logic              rd_ready;
    logic              rd_valid;
    logic [WORD_W-1:0] rd_data;
    logic [15:0]       miss_count;

    logic [ADDR_W-1:0] ram_address;
    logic [2:0]        ram_cmd;
    logic              ram_en;
    logic              ram_rdy;
    logic              ram_rd_valid;
    logic              ram_rd_data_end;
    logic [BEAT_W-1:0] ram_rd_data;

    modport slave (
        input  rd_req, rd_addr, flush,
        input  ram_rdy, ram_rd_valid, ram_rd_data_end, ram_rd_data,
        output rd_ready, rd_valid, rd_data, miss_count,
        output ram_address, ram_cmd, ram_en
    );

    modport master (
        output rd_req, rd_addr, flush,
        output ram_rdy, ram_rd_valid, ram_rd_data_end, ram_rd_data,
        input  rd_ready, rd_valid, rd_data, miss_count,
        input  ram_address, ram_cmd, ram_en
    );
endinterface

// File: rtl/ram_burst_cache_reader.sv
// ram_burst_cache_reader
//   Direct-mapped read cache in front of a DDR3 UI read port. A hit returns the
//   word one cycle after acceptance; a miss issues one burst read, fills the
//   line beat by beat and returns the requested word from the new line.
//   Ports:
//     clk   : sole clock, rising edge
//     reset : asynchronous, active-high
//     bus   : ram_burst_cache_reader_if.slave (user read port + UI read port)
//
//   state | meaning
//   IDLE  | ready for a request; hits are answered from here
//   CMD   | read command presented on the UI until ram_rdy
//   FILL  | collecting burst beats into the line
//   RESP  | rd_valid pulse carrying the word from the freshly filled line
module ram_burst_cache_reader #(
    parameter int ADDR_W = 27,
    parameter int WORD_W = 16,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 2,
    parameter int LINES  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    ram_burst_cache_reader_if.slave bus
);
    localparam int LINE_W = BEATS * BEAT_W;
    localparam int WPL    = LINE_W / WORD_W;
    localparam int OFF_W  = $clog2(WPL);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [LINES-1:0]  line_valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];

    logic [ADDR_W-1:0] cap_addr;
    logic [CNT_W-1:0]  beat_cnt;
    logic              flush_pend;
    logic              rd_valid_q;
    logic [WORD_W-1:0] rd_data_q;
    logic [15:0]       miss_cnt_q;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [OFF_W-1:0]  cap_off;
    logic [IDX_W-1:0]  cap_idx;
    logic [TAG_W-1:0]  cap_tag;

    logic              accept;
    logic              hit;
    logic              miss;
    logic              beat_we;
    logic              fill_done;
    logic [LINE_W-1:0] hit_line;
    logic [WORD_W-1:0] hit_word;
    logic [LINE_W-1:0] filled_line;
    logic [WORD_W-1:0] fill_word;

    logic              ram_en_c;
    logic [2:0]        ram_cmd_c;
    logic [ADDR_W-1:0] ram_address_c;

    assign req_off = bus.rd_addr[OFF_W-1:0];
    assign req_idx = bus.rd_addr[OFF_W +: IDX_W];
    assign req_tag = bus.rd_addr[ADDR_W-1 -: TAG_W];
    assign cap_off = cap_addr[OFF_W-1:0];
    assign cap_idx = cap_addr[OFF_W +: IDX_W];
    assign cap_tag = cap_addr[ADDR_W-1 -: TAG_W];

    // A flush in the acceptance cycle wins: the lookup sees an empty cache.
    assign accept = bus.rd_req && (state == IDLE);
    assign hit    = accept && !bus.flush && line_valid[req_idx] &&
                    (tag_mem[req_idx] == req_tag);
    assign miss   = accept && !hit;

    assign hit_line = data_mem[req_idx];
    assign hit_word = hit_line[req_off*WORD_W +: WORD_W];

    // Beats are only taken in FILL; strays elsewhere are dropped.
    assign beat_we   = (state == FILL) && bus.ram_rd_valid;
    assign fill_done = beat_we && (bus.ram_rd_data_end || (beat_cnt == LAST_BEAT));

    // Line as it will look after this cycle's beat, so the RESP word
    // already includes the final beat.
    always_comb begin
        filled_line = data_mem[cap_idx];
        filled_line[beat_cnt*BEAT_W +: BEAT_W] = bus.ram_rd_data;
    end

    assign fill_word = filled_line[cap_off*WORD_W +: WORD_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        ram_en_c      = 1'b0;
        ram_cmd_c     = 3'b000;
        ram_address_c = '0;
        unique case (state)
            IDLE: begin
                if (miss) state_next = CMD;
            end
            CMD: begin
                ram_en_c      = 1'b1;
                ram_cmd_c     = 3'b001;
                ram_address_c = {cap_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                if (bus.ram_rdy) state_next = FILL;
            end
            FILL: begin
                if (fill_done) state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_valid <= '0;
            cap_addr   <= '0;
            beat_cnt   <= '0;
            flush_pend <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            rd_valid_q <= 1'b0;

            if (accept) cap_addr <= bus.rd_addr;

            if (hit) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= hit_word;
            end

            if (miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;

            if (beat_we) beat_cnt <= beat_cnt + CNT_W'(1);

            if (bus.flush) line_valid <= '0;

            // A flush seen while filling must keep the new line invalid.
            if (bus.flush && (state == FILL)) flush_pend <= 1'b1;

            if (fill_done) begin
                beat_cnt   <= '0;
                flush_pend <= 1'b0;
                rd_valid_q <= 1'b1;
                rd_data_q  <= fill_word;
                if (!flush_pend && !bus.flush) line_valid[cap_idx] <= 1'b1;
            end
        end
    end

    // Line storage needs no reset; validity alone decides what can hit.
    always_ff @(posedge clk) begin
        if (beat_we)   data_mem[cap_idx] <= filled_line;
        if (fill_done) tag_mem[cap_idx]  <= cap_tag;
    end

    assign bus.rd_ready    = (state == IDLE);
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.miss_count  = miss_cnt_q;
    assign bus.ram_en      = ram_en_c;
    assign bus.ram_cmd     = ram_cmd_c;
    assign bus.ram_address = ram_address_c;
endmodule
